if_fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32IM pipeline. It holds the fetch address, runs the read handshake with the instruction memory, and applies branch/jump redirects from EX. It presents `PC_IF`, `INSTRUCTION_IF` and `IMEM_BUSYWAIT` to the IF/ID pipeline register, and uses the same advance condition as that register so that the two stay in lockstep.

---
 rtl/if_fetch_stage.sv | 128 ++++++++++++
 tb/tb_if_fetch_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch address, runs the IMEM read handshake
// and applies EX redirects, advancing in lockstep with the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HOLD,
  input  logic        MEM_BUSYWAIT,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_ACK,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC_IF,
  output logic [31:0] INSTRUCTION_IF,
  output logic        IMEM_BUSYWAIT
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] VALID = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic [31:0] instr_buf_reg, instr_buf_next;

  logic        adv;
  logic        ack;
  logic [31:0] target;
  logic [31:0] req_addr_inc;

  assign adv          = !HOLD && !MEM_BUSYWAIT;
  // An acknowledge seen while reset is held belongs to an abandoned read.
  assign ack          = IMEM_ACK && !RESET;
  assign target       = BRANCH_TARGET & 32'hFFFF_FFFC;
  assign req_addr_inc = req_addr_reg + 32'd4;

  always_comb begin
    state_next     = state_reg;
    req_addr_next  = req_addr_reg;
    pend_pc_next   = pend_pc_reg;
    instr_buf_next = instr_buf_reg;
    case (state_reg)
      FETCH: begin
        if (BRANCH_TAKEN) begin
          if (ack) begin
            req_addr_next = target;
          end else begin
            // Keep the in-flight address stable; the target waits in pend_pc.
            pend_pc_next = target;
            state_next   = DROP;
          end
        end else if (ack) begin
          if (adv) begin
            req_addr_next = req_addr_inc;
          end else begin
            instr_buf_next = IMEM_READDATA;
            state_next     = VALID;
          end
        end
      end
      VALID: begin
        if (BRANCH_TAKEN) begin
          req_addr_next = target;
          state_next    = FETCH;
        end else if (adv) begin
          req_addr_next = req_addr_inc;
          state_next    = FETCH;
        end
      end
      DROP: begin
        if (BRANCH_TAKEN) begin
          pend_pc_next = target;
        end
        if (ack) begin
          req_addr_next = BRANCH_TAKEN ? target : pend_pc_reg;
          state_next    = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= FETCH;
      req_addr_reg  <= RESET_PC;
      pend_pc_reg   <= RESET_PC;
      instr_buf_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      req_addr_reg  <= req_addr_next;
      pend_pc_reg   <= pend_pc_next;
      instr_buf_reg <= instr_buf_next;
    end
  end

  assign IMEM_ADDR = req_addr_reg;
  assign PC_IF     = req_addr_reg;
  assign IMEM_READ = !RESET && (state_reg != VALID);

  always_comb begin
    INSTRUCTION_IF = 32'd0;
    IMEM_BUSYWAIT  = 1'b1;
    case (state_reg)
      FETCH: begin
        if (ack) begin
          INSTRUCTION_IF = IMEM_READDATA;
          IMEM_BUSYWAIT  = 1'b0;
        end
      end
      VALID: begin
        INSTRUCTION_IF = instr_buf_reg;
        IMEM_BUSYWAIT  = 1'b0;
      end
      default: begin
        INSTRUCTION_IF = 32'd0;
        IMEM_BUSYWAIT  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a variable-latency memory responder and a
// transaction-level model of the fetch stream checked every cycle.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        HOLD = 1'b0;
  logic        MEM_BUSYWAIT = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic [31:0] IMEM_READDATA = 32'd0;
  logic        IMEM_ACK = 1'b0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] PC_IF;
  logic [31:0] INSTRUCTION_IF;
  logic        IMEM_BUSYWAIT;

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RESET(RESET), .HOLD(HOLD), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_READDATA(IMEM_READDATA), .IMEM_ACK(IMEM_ACK),
    .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR), .PC_IF(PC_IF),
    .INSTRUCTION_IF(INSTRUCTION_IF), .IMEM_BUSYWAIT(IMEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the fetch stream: the address on the bus, whether an instruction
  // is being held for a stalled pipeline, and whether the read in flight is stale.
  logic [31:0] m_addr;
  logic        m_held;
  logic [31:0] m_word;
  logic        m_stale;
  logic [31:0] m_target;
  int          lat_cnt;
  int          lat_goal;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr   = RST_PC;
    m_held   = 1'b0;
    m_word   = 32'd0;
    m_stale  = 1'b0;
    m_target = RST_PC;
    lat_cnt  = 0;
    lat_goal = 0;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFC;
      1: return 32'h0000_0403;
      2: return {20'd0, 12'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check_outputs();
    check32("imem_read", {31'd0, IMEM_READ}, {31'd0, !m_held});
    check32("imem_addr", IMEM_ADDR, m_addr);
    check32("pc_if", PC_IF, m_addr);
    if (m_held) begin
      check32("instr_held", INSTRUCTION_IF, m_word);
      check32("busy_held", {31'd0, IMEM_BUSYWAIT}, 32'd0);
    end else if (m_stale || !IMEM_ACK) begin
      check32("instr_wait", INSTRUCTION_IF, 32'd0);
      check32("busy_wait", {31'd0, IMEM_BUSYWAIT}, 32'd1);
    end else begin
      check32("instr_ack", INSTRUCTION_IF, mem_word(m_addr));
      check32("busy_ack", {31'd0, IMEM_BUSYWAIT}, 32'd0);
    end
  endtask

  task automatic do_cycle();
    logic [31:0] tgt;
    logic        adv;
    @(negedge CLK);
    HOLD          = ($urandom_range(0, 99) < 20);
    MEM_BUSYWAIT  = ($urandom_range(0, 99) < 15);
    BRANCH_TAKEN  = ($urandom_range(0, 99) < 10);
    BRANCH_TARGET = pick_target();
    IMEM_ACK      = IMEM_READ && (lat_cnt >= lat_goal);
    IMEM_READDATA = IMEM_ACK ? mem_word(IMEM_ADDR) : 32'($urandom);
    #1;
    check_outputs();
    @(posedge CLK);
    tgt = BRANCH_TARGET & 32'hFFFF_FFFC;
    adv = !HOLD && !MEM_BUSYWAIT;
    if (m_held) begin
      if (BRANCH_TAKEN) begin m_addr = tgt; m_held = 1'b0; end
      else if (adv) begin m_addr = m_addr + 32'd4; m_held = 1'b0; end
    end else if (m_stale) begin
      if (BRANCH_TAKEN) m_target = tgt;
      if (IMEM_ACK) begin m_addr = BRANCH_TAKEN ? tgt : m_target; m_stale = 1'b0; end
    end else if (BRANCH_TAKEN) begin
      if (IMEM_ACK) m_addr = tgt;
      else begin m_stale = 1'b1; m_target = tgt; end
    end else if (IMEM_ACK) begin
      if (adv) m_addr = m_addr + 32'd4;
      else begin m_held = 1'b1; m_word = mem_word(m_addr); end
    end
    if (IMEM_ACK || !IMEM_READ) begin
      lat_cnt  = 0;
      lat_goal = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    end else begin
      lat_cnt++;
    end
  endtask

  // Asserts reset asynchronously in the middle of a cycle, then releases it.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    RESET        = 1'b1;
    IMEM_ACK     = 1'b0;
    BRANCH_TAKEN = 1'b0;
    #1;
    repeat (2) begin
      check32("rst_read", {31'd0, IMEM_READ}, 32'd0);
      check32("rst_busy", {31'd0, IMEM_BUSYWAIT}, 32'd1);
      check32("rst_instr", INSTRUCTION_IF, 32'd0);
      check32("rst_pc", PC_IF, RST_PC);
      check32("rst_addr", IMEM_ADDR, RST_PC);
      @(negedge CLK);
      #1;
    end
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 700 == 699) do_reset();
      else do_cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
